// File: rtl/control_unit.sv
`timescale 1ns/1ps
// control_unit: fetch/decode sequencer for the 8-bit datapath.
// Fetches 12-bit instructions ([11:8] opcode, [7:0] immediate) over a
// request/valid handshake and drives ALUCode, R and the A/CY clock enables
// for the downstream ALU/accumulator/CY stage.
//
// ALU operation codes driven on ALUCode:
//   ADD=0 SUB=1 AND=2 OR=3 XOR=4 NOT=5 LD=6
//
// state | meaning
// ------+-----------------------------------------------------------
// FETCH | InstrReq high at InstrAddr=PC, wait for InstrValid, load IR
// EXEC  | one cycle: pulse enables for ALU ops, update PC or halt
// HALT  | core stopped, only Reset leaves this state
module control_unit #(
  parameter int PC_WIDTH = 8
) (
  input  logic                clk,
  input  logic                Reset,
  output logic [PC_WIDTH-1:0] InstrAddr,
  output logic                InstrReq,
  input  logic                InstrValid,
  input  logic [11:0]         InstrData,
  input  logic                CY,
  output logic [2:0]          ALUCode,
  output logic [7:0]          R,
  output logic                A_CE,
  output logic                CY_CE,
  output logic                Halted
);

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;
  localparam logic [2:0] ALU_NOT = 3'd5;
  localparam logic [2:0] ALU_LD  = 3'd6;

  localparam logic [3:0] OP_LD  = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_AND = 4'h4;
  localparam logic [3:0] OP_OR  = 4'h5;
  localparam logic [3:0] OP_XOR = 4'h6;
  localparam logic [3:0] OP_NOT = 4'h7;
  localparam logic [3:0] OP_JMP = 4'h8;
  localparam logic [3:0] OP_JC  = 4'h9;
  localparam logic [3:0] OP_JNC = 4'hA;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [PC_WIDTH-1:0] r_pc;
  logic [11:0]         r_ir;
  logic [3:0]          w_op;
  logic [PC_WIDTH-1:0] w_pc_inc;
  logic [PC_WIDTH-1:0] w_jump_tgt;
  logic [PC_WIDTH-1:0] w_pc_nxt;
  logic [2:0]          w_alu_map;
  logic                w_is_alu_op;

  assign w_op       = r_ir[11:8];
  assign w_pc_inc   = r_pc + PC_WIDTH'(1);
  assign w_jump_tgt = PC_WIDTH'(r_ir[7:0]);
  assign w_is_alu_op = (w_op >= OP_LD) && (w_op <= OP_NOT);
  assign InstrAddr  = r_pc;

  // State register; Reset returns to FETCH from anywhere, including HALT.
  always_ff @(posedge clk) begin
    if (Reset) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // PC and IR; IR loads only on an accepted fetch, PC moves only in EXEC.
  always_ff @(posedge clk) begin
    if (Reset) begin
      r_pc <= '0;
      r_ir <= '0;
    end else begin
      if ((r_state == S_FETCH) && InstrValid) begin
        r_ir <= InstrData;
      end
      if ((r_state == S_EXEC) && (w_op != OP_HLT)) begin
        r_pc <= w_pc_nxt;
      end
    end
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_FETCH: if (InstrValid) w_state_nxt = S_EXEC;
      S_EXEC:  w_state_nxt = (w_op == OP_HLT) ? S_HALT : S_FETCH;
      S_HALT:  w_state_nxt = S_HALT;
      default: w_state_nxt = S_FETCH;
    endcase
  end

  // Next PC: jumps resolve against the CY value seen during EXEC.
  always_comb begin
    w_pc_nxt = w_pc_inc;
    case (w_op)
      OP_JMP:  w_pc_nxt = w_jump_tgt;
      OP_JC:   w_pc_nxt = CY ? w_jump_tgt : w_pc_inc;
      OP_JNC:  w_pc_nxt = CY ? w_pc_inc : w_jump_tgt;
      default: w_pc_nxt = w_pc_inc;
    endcase
  end

  // Opcode to ALU code; non-ALU opcodes fall back to LD.
  always_comb begin
    w_alu_map = ALU_LD;
    case (w_op)
      OP_LD:   w_alu_map = ALU_LD;
      OP_ADD:  w_alu_map = ALU_ADD;
      OP_SUB:  w_alu_map = ALU_SUB;
      OP_AND:  w_alu_map = ALU_AND;
      OP_OR:   w_alu_map = ALU_OR;
      OP_XOR:  w_alu_map = ALU_XOR;
      OP_NOT:  w_alu_map = ALU_NOT;
      default: w_alu_map = ALU_LD;
    endcase
  end

  // Outputs; Reset masks everything combinationally so a reset landing in
  // EXEC never lets an enable through.
  always_comb begin
    InstrReq = 1'b0;
    A_CE     = 1'b0;
    CY_CE    = 1'b0;
    Halted   = 1'b0;
    ALUCode  = ALU_LD;
    R        = 8'h00;
    if (!Reset) begin
      ALUCode = w_alu_map;
      R       = r_ir[7:0];
      case (r_state)
        S_FETCH: InstrReq = 1'b1;
        S_EXEC: begin
          A_CE  = w_is_alu_op;
          CY_CE = (w_op == OP_ADD) || (w_op == OP_SUB);
        end
        S_HALT:  Halted = 1'b1;
        default: InstrReq = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit.sv
`timescale 1ns/1ps
// tb_control_unit: drives control_unit with a behavioural program memory and
// an ALU/accumulator/CY environment, and compares every cycle against an
// instruction-level reference model of the sequencer.
module tb_control_unit;

  localparam logic [2:0] C_ADD = 3'd0;
  localparam logic [2:0] C_SUB = 3'd1;
  localparam logic [2:0] C_AND = 3'd2;
  localparam logic [2:0] C_OR  = 3'd3;
  localparam logic [2:0] C_XOR = 3'd4;
  localparam logic [2:0] C_NOT = 3'd5;
  localparam logic [2:0] C_LD  = 3'd6;

  logic        clk = 1'b0;
  logic        Reset = 1'b1;
  logic [7:0]  InstrAddr;
  logic        InstrReq;
  logic        InstrValid = 1'b0;
  logic [11:0] InstrData = 12'h000;
  logic [2:0]  ALUCode;
  logic [7:0]  R;
  logic        A_CE, CY_CE, Halted;

  logic [7:0]  env_acc = 8'h00;
  logic        env_cy  = 1'b0;

  always #5 clk = ~clk;

  control_unit #(.PC_WIDTH(8)) dut (
    .clk(clk), .Reset(Reset), .InstrAddr(InstrAddr), .InstrReq(InstrReq),
    .InstrValid(InstrValid), .InstrData(InstrData), .CY(env_cy),
    .ALUCode(ALUCode), .R(R), .A_CE(A_CE), .CY_CE(CY_CE), .Halted(Halted)
  );

  int checks = 0;
  int errors = 0;

  logic [11:0] mem [256];
  bit          rst_req = 1'b1;
  bit          rand_stall = 1'b0;
  bit          noise = 1'b0;
  int          stall_cnt = 0;
  int          ace_cnt = 0;
  int          cyce_cnt = 0;

  logic       s_req, s_ace, s_cyce, s_halt;
  logic [7:0] s_addr, s_r;
  logic [2:0] s_alu;

  // instruction-level reference model
  logic [7:0]  m_pc = 8'h00;
  logic [11:0] m_ir = 12'h000;
  logic [7:0]  m_acc = 8'h00;
  logic        m_cy = 1'b0;
  bit          m_exec = 1'b0;
  bit          m_halted = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] map_alu(input logic [3:0] op);
    case (op)
      4'h2: return C_ADD;
      4'h3: return C_SUB;
      4'h4: return C_AND;
      4'h5: return C_OR;
      4'h6: return C_XOR;
      4'h7: return C_NOT;
      default: return C_LD;
    endcase
  endfunction

  task automatic model_exec();
    logic [3:0] op;
    logic [7:0] imm;
    logic [8:0] sum;
    op  = m_ir[11:8];
    imm = m_ir[7:0];
    case (op)
      4'h1: m_acc = imm;
      4'h2: begin sum = {1'b0, m_acc} + {1'b0, imm}; m_acc = sum[7:0]; m_cy = sum[8]; end
      4'h3: begin m_cy = (m_acc < imm); m_acc = m_acc - imm; end
      4'h4: m_acc = m_acc & imm;
      4'h5: m_acc = m_acc | imm;
      4'h6: m_acc = m_acc ^ imm;
      4'h7: m_acc = ~m_acc;
      default: ;
    endcase
    case (op)
      4'h8: m_pc = imm;
      4'h9: m_pc = m_cy ? imm : m_pc + 8'd1;
      4'hA: m_pc = m_cy ? m_pc + 8'd1 : imm;
      4'hF: m_halted = 1'b1;
      default: m_pc = m_pc + 8'd1;
    endcase
  endtask

  // One clock cycle: apply Reset, check outputs, answer the fetch, advance.
  task automatic step();
    logic       e_req, e_ace, e_cyce, e_halt;
    logic [2:0] e_alu;
    logic [7:0] e_r, n_acc, res;
    logic       n_cy, c;
    logic [3:0] op;
    logic [8:0] sum;
    @(negedge clk);
    Reset = rst_req;
    #1;
    s_req = InstrReq; s_addr = InstrAddr; s_ace = A_CE; s_cyce = CY_CE;
    s_halt = Halted; s_alu = ALUCode; s_r = R;
    op = m_ir[11:8];
    if (rst_req) begin
      e_req = 0; e_ace = 0; e_cyce = 0; e_halt = 0; e_alu = C_LD; e_r = 8'h00;
    end else begin
      e_alu  = map_alu(op);
      e_r    = m_ir[7:0];
      e_halt = m_halted;
      e_req  = !m_halted && !m_exec;
      e_ace  = !m_halted && m_exec && (op >= 4'h1) && (op <= 4'h7);
      e_cyce = !m_halted && m_exec && ((op == 4'h2) || (op == 4'h3));
    end
    chk("InstrReq", 32'(s_req), 32'(e_req));
    chk("A_CE", 32'(s_ace), 32'(e_ace));
    chk("CY_CE", 32'(s_cyce), 32'(e_cyce));
    chk("Halted", 32'(s_halt), 32'(e_halt));
    chk("ALUCode", 32'(s_alu), 32'(e_alu));
    chk("R", 32'(s_r), 32'(e_r));
    if (e_req) chk("InstrAddr", 32'(s_addr), 32'(m_pc));
    chk("acc", 32'(env_acc), 32'(m_acc));
    chk("cy", 32'(env_cy), 32'(m_cy));
    if (s_ace) ace_cnt++;
    if (s_cyce) cyce_cnt++;

    if (rst_req) begin
      InstrValid = 1'b1;
      InstrData  = 12'($urandom);
    end else if (s_req) begin
      if (stall_cnt > 0) begin
        InstrValid = 1'b0;
        InstrData  = 12'($urandom);
        stall_cnt--;
      end else begin
        InstrValid = 1'b1;
        InstrData  = mem[s_addr];
        if (rand_stall) stall_cnt = $urandom_range(0, 2);
      end
    end else begin
      InstrValid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      InstrData  = 12'($urandom);
    end

    n_acc = env_acc; n_cy = env_cy; res = env_acc; c = 1'b0;
    case (s_alu)
      C_ADD: begin sum = {1'b0, env_acc} + {1'b0, s_r}; res = sum[7:0]; c = sum[8]; end
      C_SUB: begin res = env_acc - s_r; c = (env_acc < s_r); end
      C_AND: res = env_acc & s_r;
      C_OR:  res = env_acc | s_r;
      C_XOR: res = env_acc ^ s_r;
      C_NOT: res = ~env_acc;
      C_LD:  res = s_r;
      default: res = env_acc;
    endcase
    if (s_ace) n_acc = res;
    if (s_cyce) n_cy = c;

    if (rst_req) begin
      m_pc = 8'h00; m_ir = 12'h000; m_exec = 0; m_halted = 0;
    end else if (m_halted) begin
    end else if (m_exec) begin
      model_exec();
      m_exec = 0;
    end else if (InstrValid) begin
      m_ir = InstrData;
      m_exec = 1;
    end

    @(posedge clk);
    #1;
    env_acc = n_acc;
    env_cy  = n_cy;
  endtask

  task automatic do_reset(input int n);
    rst_req = 1'b1;
    repeat (n) step();
    rst_req = 1'b0;
  endtask

  task automatic fill_mem(input logic [11:0] v);
    for (int i = 0; i < 256; i++) mem[i] = v;
  endtask

  typedef struct {
    logic [11:0] instr;
    logic [7:0]  acc;
    int          cyce;
  } arith_t;

  typedef struct {
    logic [7:0] add_imm;
    logic [3:0] jop;
    logic [7:0] exp_addr;
    logic       exp_cy;
  } branch_t;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    arith_t  av[4];
    branch_t bv[4];
    av[0] = '{12'h104, 8'd4,   0};
    av[1] = '{12'h204, 8'd8,   1};
    av[2] = '{12'h303, 8'd5,   1};
    av[3] = '{12'h700, 8'd250, 0};
    bv[0] = '{8'h01, 4'h9, 8'h20, 1'b1};
    bv[1] = '{8'h00, 4'h9, 8'h03, 1'b0};
    bv[2] = '{8'h01, 4'hA, 8'h03, 1'b1};
    bv[3] = '{8'h00, 4'hA, 8'h20, 1'b0};

    // reset, with InstrValid held high during reset
    fill_mem(12'h000);
    do_reset(2);
    step();
    chk("rst_req", 32'(s_req), 32'd1);
    chk("rst_addr", 32'(s_addr), 32'd0);
    chk("rst_ace", 32'(s_ace | s_cyce), 32'd0);
    chk("rst_halt", 32'(s_halt), 32'd0);
    chk("rst_alu", 32'(s_alu), 32'(C_LD));
    chk("rst_r", 32'(s_r), 32'd0);

    // arithmetic sequence, zero-wait memory
    fill_mem(12'hF00);
    for (int i = 0; i < 4; i++) mem[i] = av[i].instr;
    do_reset(1);
    for (int i = 0; i < 4; i++) begin
      ace_cnt = 0; cyce_cnt = 0;
      step(); step();
      chk("arith_acc", 32'(env_acc), 32'(av[i].acc));
      chk("arith_ace_pulses", 32'(ace_cnt), 32'd1);
      chk("arith_cyce_pulses", 32'(cyce_cnt), 32'(av[i].cyce));
    end

    // carry-conditional branches
    for (int i = 0; i < 4; i++) begin
      fill_mem(12'hF00);
      mem[0] = 12'h1FF;
      mem[1] = {4'h2, bv[i].add_imm};
      mem[2] = {bv[i].jop, 8'h20};
      do_reset(1);
      repeat (6) step();
      step();
      chk("branch_cy", 32'(env_cy), 32'(bv[i].exp_cy));
      chk("branch_req", 32'(s_req), 32'd1);
      chk("branch_addr", 32'(s_addr), 32'(bv[i].exp_addr));
    end

    // fetch stall of 3 cycles at address 5
    fill_mem(12'h000);
    mem[5] = 12'h155;
    mem[6] = 12'hF00;
    do_reset(1);
    repeat (10) step();
    stall_cnt = 3;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stall_req", 32'(s_req), 32'd1);
      chk("stall_addr", 32'(s_addr), 32'd5);
      chk("stall_ace", 32'(s_ace), 32'd0);
    end
    step();
    chk("stall_valid_req", 32'(s_req), 32'd1);
    chk("stall_valid_ace", 32'(s_ace), 32'd0);
    step();
    chk("stall_exec_ace", 32'(s_ace), 32'd1);
    chk("stall_acc", 32'(env_acc), 32'h55);

    // PC wrap at 0xFF, then halt at 0x00
    fill_mem(12'h000);
    mem[0] = 12'h8FF;
    do_reset(1);
    step(); step();
    mem[0] = 12'hF00;
    step();
    chk("wrap_addr_ff", 32'(s_addr), 32'hFF);
    step();
    step();
    chk("wrap_req", 32'(s_req), 32'd1);
    chk("wrap_addr_00", 32'(s_addr), 32'h00);
    step();
    for (int k = 0; k < 10; k++) begin
      step();
      chk("halt_halted", 32'(s_halt), 32'd1);
      chk("halt_req", 32'(s_req), 32'd0);
    end
    rst_req = 1'b1;
    step();
    chk("halt_rst_clear", 32'(s_halt), 32'd0);
    rst_req = 1'b0;
    step();
    chk("halt_restart_req", 32'(s_req), 32'd1);
    chk("halt_restart_addr", 32'(s_addr), 32'd0);

    // reset landing in EXEC of ADD
    fill_mem(12'h000);
    mem[0] = 12'h101;
    mem[1] = 12'h202;
    mem[2] = 12'hF00;
    do_reset(1);
    repeat (3) step();
    rst_req = 1'b1;
    step();
    chk("midexec_ace", 32'(s_ace), 32'd0);
    chk("midexec_cyce", 32'(s_cyce), 32'd0);
    rst_req = 1'b0;
    step();
    chk("midexec_req", 32'(s_req), 32'd1);
    chk("midexec_addr", 32'(s_addr), 32'd0);
    chk("midexec_acc", 32'(env_acc), 32'd1);

    // randomized programs, stalls, stray InstrValid and resets
    for (int i = 0; i < 256; i++) begin
      logic [3:0] op;
      op = 4'($urandom_range(0, 15));
      if ((op == 4'hF) && ($urandom_range(0, 3) != 0)) op = 4'h0;
      mem[i] = {op, 8'($urandom)};
    end
    rand_stall = 1'b1;
    noise = 1'b1;
    do_reset(1);
    for (int n = 0; n < 3000; n++) begin
      rst_req = ($urandom_range(0, 99) == 0);
      step();
    end
    rst_req = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
